// File: rtl/mux4_scan_ctrl.sv
// mux4_scan_ctrl: steps s1/s0 over a 4:1 mux (clk, rst, start/cont/stop, y in; s1/s0, frame, frame_valid, busy out)
module mux4_scan_ctrl #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       stop,
  input  logic       y,
  output logic       s1,
  output logic       s0,
  output logic [3:0] frame,
  output logic       frame_valid,
  output logic       busy
);
  localparam int CW = $clog2(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;
  logic [0:0] state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] shadow_q, shadow_d;
  logic stop_pend_q, stop_pend_d;
  logic [3:0] frame_q, frame_d;
  logic fv_q, fv_d;
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    shadow_d = shadow_q;
    stop_pend_d = stop_pend_q;
    frame_d = frame_q;
    fv_d = 1'b0;
    if (state_q == IDLE) begin
      state_d = start ? SCAN : IDLE;
      sel_d = 2'd0;
      cnt_d = '0;
    end else begin
      stop_pend_d = stop_pend_q | stop;
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      if (cnt_q == LAST && sel_q != 2'd3) begin
        shadow_d = {sel_q == 2'd2 ? y : shadow_q[2],
                    sel_q == 2'd1 ? y : shadow_q[1],
                    sel_q == 2'd0 ? y : shadow_q[0]};
        sel_d = sel_q + 2'd1;
      end else if (cnt_q == LAST) begin
        frame_d = {y, shadow_q};
        fv_d = 1'b1;
        sel_d = 2'd0;
        stop_pend_d = 1'b0;
        state_d = (cont && !stop_pend_q && !stop) ? SCAN : IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q <= 2'd0;
      cnt_q <= '0;
      shadow_q <= 3'd0;
      stop_pend_q <= 1'b0;
      frame_q <= 4'd0;
      fv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      shadow_q <= shadow_d;
      stop_pend_q <= stop_pend_d;
      frame_q <= frame_d;
      fv_q <= fv_d;
    end
  end
  assign {s1, s0} = sel_q;
  assign frame = frame_q;
  assign frame_valid = fv_q;
  assign busy = state_q == SCAN;
endmodule
